// File: rtl/ir_stat_unit.sv
// ir_stat_unit: instruction-side partner of the SISC control FSM.
// Fetches an instruction word over a req/ack handshake into the IR,
// decodes its fields, keeps the {C,V,N,Z} status register and evaluates
// the branch condition for BRA/BRR/BNE/BNR.
//
// Memory handshake: imem_rd is high for as long as a fetch is outstanding
// (REQ and WAIT). The memory answers by raising imem_ack for one cycle
// while imem_data is valid; the word is captured on that edge and imem_rd
// drops. An ack seen while imem_rd is low is ignored. REQ is the first
// cycle of the outstanding request, so an ack in REQ is accepted and
// gives the two-cycle fetch_req-to-ir_valid minimum latency.
module ir_stat_unit #(
    parameter int IW       = 32,
    parameter int SW       = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    output logic          imem_rd,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    output logic          ir_valid,
    output logic [3:0]    opcode,
    output logic [3:0]    mm,
    output logic [3:0]    rd,
    output logic [3:0]    rs,
    output logic [3:0]    rt,
    output logic [15:0]   imm,
    input  logic          stat_en,
    input  logic [SW-1:0] alu_flags,
    output logic [SW-1:0] stat,
    output logic          br_taken,
    output logic          fetch_err,
    output logic [1:0]    dbg_state
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    localparam logic [3:0] OP_BRA = 4'd4;
    localparam logic [3:0] OP_BRR = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;
    localparam logic [3:0] OP_BNR = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [SW-1:0] stat_q;
    logic [CW-1:0] cnt_inc;
    logic          hit;
    logic          br_c;

    // Fetch FSM, IR, wait counter and sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: the counter holds the number of unanswered request
    // cycles of the current fetch; reaching MAX_WAIT aborts the fetch.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cnt_inc = '0;
        case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    state_d = S_REQ;
                end
            end
            S_REQ, S_WAIT: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    // REQ restarts the count; WAIT extends it.
                    cnt_inc = (state_q == S_REQ) ? CW'(1) : cnt_q + CW'(1);
                    cnt_d   = cnt_inc;
                    if (cnt_inc == CW'(MAX_WAIT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_HOLD: begin
                if (fetch_req) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status register: loads from the ALU flags whenever enabled,
    // independently of the fetch FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else if (stat_en) begin
            stat_q <= alu_flags;
        end
    end

    // Branch condition from the current IR and the registered status, so a
    // same-cycle stat_en is only seen from the following cycle on.
    always_comb begin
        hit  = |(mm & stat_q);
        br_c = 1'b0;
        case (opcode)
            OP_BRA, OP_BRR: br_c = hit;
            OP_BNE, OP_BNR: br_c = ~hit;
            default:        br_c = 1'b0;
        endcase
    end

    assign imem_rd   = (state_q == S_REQ) || (state_q == S_WAIT);
    assign ir_valid  = (state_q == S_HOLD);
    assign opcode    = ir_q[IW-1:IW-4];
    assign mm        = ir_q[IW-5:IW-8];
    assign rd        = ir_q[IW-9:IW-12];
    assign rs        = ir_q[IW-13:IW-16];
    assign rt        = ir_q[IW-17:IW-20];
    assign imm       = ir_q[15:0];
    assign stat      = stat_q;
    assign br_taken  = br_c;
    assign fetch_err = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ir_stat_unit.sv
// Testbench for ir_stat_unit: directed scenarios followed by randomized
// fetches and status updates, checked by a scoreboard of expected IR words
// and a reference model of decode, status and branch behaviour.
module tb_ir_stat_unit;

    localparam int MAX_WAIT = 15;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        fetch_req = 1'b0;
    logic        imem_rd;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        ir_valid;
    logic [3:0]  opcode, mm, rd, rs, rt;
    logic [15:0] imm;
    logic        stat_en = 1'b0;
    logic [3:0]  alu_flags = '0;
    logic [3:0]  stat;
    logic        br_taken;
    logic        fetch_err;
    logic [1:0]  dbg_state;

    ir_stat_unit dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .imem_rd   (imem_rd),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .ir_valid  (ir_valid),
        .opcode    (opcode),
        .mm        (mm),
        .rd        (rd),
        .rs        (rs),
        .rt        (rt),
        .imm       (imm),
        .stat_en   (stat_en),
        .alu_flags (alu_flags),
        .stat      (stat),
        .br_taken  (br_taken),
        .fetch_err (fetch_err),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ir_m = '0;
    logic [3:0]  stat_m = '0;
    logic        err_m = 1'b0;
    logic        prev_v = 1'b0;
    bit          rand_stat_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Branch rule: hit when any flag selected by mm is set.
    function automatic logic br_model(input logic [31:0] w, input logic [3:0] s);
        logic [3:0] op;
        logic       h;
        op = w[31:28];
        h  = (w[27:24] & s) != 4'd0;
        if (op == 4'd4 || op == 4'd5) return h;
        if (op == 4'd6 || op == 4'd7) return !h;
        return 1'b0;
    endfunction

    // Status model: takes alu_flags on any enabled edge.
    always @(posedge clk or posedge rst) begin
        if (rst) stat_m = '0;
        else if (stat_en) stat_m = alu_flags;
    end

    // Monitor: pops an expected word whenever a new instruction becomes
    // valid, then compares every decode/status output each cycle.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            ir_m   = '0;
            prev_v = 1'b0;
            err_m  = 1'b0;
            exp_q.delete();
        end else begin
            if (ir_valid && !prev_v) begin
                if (exp_q.size() == 0) chk("unexpected_ir_valid", 32'(ir_valid), 32'(0));
                else ir_m = exp_q.pop_front();
            end
            prev_v = ir_valid;
            chk("opcode",    32'(opcode),    32'(ir_m[31:28]));
            chk("mm",        32'(mm),        32'(ir_m[27:24]));
            chk("rd",        32'(rd),        32'(ir_m[23:20]));
            chk("rs",        32'(rs),        32'(ir_m[19:16]));
            chk("rt",        32'(rt),        32'(ir_m[15:12]));
            chk("imm",       32'(imm),       32'(ir_m[15:0]));
            chk("stat",      32'(stat),      32'(stat_m));
            chk("br_taken",  32'(br_taken),  32'(br_model(ir_m, stat_m)));
            chk("fetch_err", 32'(fetch_err), 32'(err_m));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_stat_on) begin
            stat_en   = ($urandom_range(0, 3) == 0);
            alu_flags = 4'($urandom);
        end
    endtask

    // One fetch; k = number of unanswered request cycles before the ack.
    // k >= MAX_WAIT means the memory never answers.
    task automatic fetch(input logic [31:0] data, input int k);
        int rd_cnt;
        int n;
        rd_cnt    = 0;
        n         = (k >= MAX_WAIT) ? MAX_WAIT : k;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            imem_ack  = 1'b0;
            imem_data = $urandom;
            @(negedge clk);
            if (imem_rd) rd_cnt++;
            if (i == n - 1 && k >= MAX_WAIT) chk("err_not_early", 32'(fetch_err), 32'(err_m));
            step();
        end
        if (k >= MAX_WAIT) begin
            err_m = 1'b1;
            @(negedge clk);
            chk("timeout_err",   32'(fetch_err), 32'(1));
            chk("timeout_rd",    32'(imem_rd),   32'(0));
            chk("timeout_valid", 32'(ir_valid),  32'(0));
            chk("rd_cycles",     32'(rd_cnt),    32'(MAX_WAIT));
        end else begin
            imem_ack  = 1'b1;
            imem_data = data;
            exp_q.push_back(data);
            @(negedge clk);
            if (imem_rd) rd_cnt++;
            step();
            imem_ack  = 1'b0;
            imem_data = $urandom;
            @(negedge clk);
            chk("valid_after_ack", 32'(ir_valid), 32'(1));
            chk("rd_drop",         32'(imem_rd),  32'(0));
            chk("rd_cycles",       32'(rd_cnt),   32'(k + 1));
        end
    endtask

    task automatic load_stat(input logic [3:0] f);
        stat_en   = 1'b1;
        alu_flags = f;
        step();
        stat_en   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_rd",   32'(imem_rd),   32'(0));
        chk("rst_ir_valid",  32'(ir_valid),  32'(0));
        chk("rst_fetch_err", 32'(fetch_err), 32'(0));
        chk("rst_stat",      32'(stat),      32'(0));
        chk("rst_opcode",    32'(opcode),    32'(0));
        chk("rst_br_taken",  32'(br_taken),  32'(0));
        rst = 1'b0;
        step();

        // Zero-wait fetch
        fetch(32'h1823_4005, 0);
        chk("zw_opcode", 32'(opcode), 32'(4'h1));
        chk("zw_mm",     32'(mm),     32'(4'h8));
        chk("zw_rd",     32'(rd),     32'(4'h2));
        chk("zw_rs",     32'(rs),     32'(4'h3));
        chk("zw_rt",     32'(rt),     32'(4'h4));
        chk("zw_imm",    32'(imm),    32'(16'h4005));

        // Wait states, including the last cycle before timeout
        fetch(32'h9ABC_DEF1, 5);
        fetch($urandom, MAX_WAIT - 1);

        // Branch truth table with stat = Z
        step();
        load_stat(4'b0001);
        fetch({4'd4, 4'd1, 24'h123456}, 0);
        chk("bra_mm1", 32'(br_taken), 32'(1));
        fetch({4'd6, 4'd1, 24'h654321}, 0);
        chk("bne_mm1", 32'(br_taken), 32'(0));
        fetch({4'd5, 4'd2, 24'h0F0F0F}, 0);
        chk("brr_mm2", 32'(br_taken), 32'(0));
        fetch({4'd7, 4'd0, 24'hA5A5A5}, 0);
        chk("bnr_mm0", 32'(br_taken), 32'(1));
        fetch({4'd8, 4'hF, 24'hFFFFFF}, 0);
        chk("alu_op", 32'(br_taken), 32'(0));

        // Simultaneous stat_en and fetch_req with BNE mm=4 in the IR
        step();
        load_stat(4'b0000);
        fetch({4'd6, 4'd4, 24'h112233}, 0);
        step();
        d2        = 32'h1234_5678;
        fetch_req = 1'b1;
        stat_en   = 1'b1;
        alu_flags = 4'b0100;
        @(negedge clk);
        chk("simul_old_stat", 32'(br_taken), 32'(1));
        chk("simul_valid",    32'(ir_valid), 32'(1));
        step();
        fetch_req = 1'b0;
        stat_en   = 1'b0;
        imem_ack  = 1'b1;
        imem_data = d2;
        exp_q.push_back(d2);
        @(negedge clk);
        chk("simul_new_stat", 32'(br_taken), 32'(0));
        chk("simul_stat",     32'(stat),     32'(4'b0100));
        chk("simul_rd",       32'(imem_rd),  32'(1));
        step();
        imem_ack = 1'b0;
        @(negedge clk);
        chk("simul_fetch_valid",  32'(ir_valid), 32'(1));
        chk("simul_fetch_opcode", 32'(opcode),   32'(4'h1));

        // Timeout keeps the IR and sets a sticky error
        fetch(32'hDEAD_BEEF, MAX_WAIT);
        chk("ir_kept_opcode", 32'(opcode), 32'(4'h1));
        chk("ir_kept_imm",    32'(imm),    32'(16'h5678));
        fetch(32'h4321_0FED, 2);
        chk("err_sticky", 32'(fetch_err), 32'(1));

        // Randomized fetches, ignored acks and status updates
        rand_stat_on = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) begin
                imem_ack  = 1'($urandom_range(0, 1));
                imem_data = $urandom;
                step();
            end
            imem_ack = 1'b0;
            fetch($urandom, $urandom_range(0, MAX_WAIT + 1));
        end
        rand_stat_on = 1'b0;
        stat_en      = 1'b0;

        // Reset in the middle of a fetch
        step();
        load_stat(4'hF);
        fetch(32'hF1E2_D3C4, 0);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("pre_rst_rd", 32'(imem_rd), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rd",     32'(imem_rd),   32'(0));
        chk("mid_rst_opcode", 32'(opcode),    32'(0));
        chk("mid_rst_imm",    32'(imm),       32'(0));
        chk("mid_rst_stat",   32'(stat),      32'(0));
        chk("mid_rst_err",    32'(fetch_err), 32'(0));
        chk("mid_rst_valid",  32'(ir_valid),  32'(0));
        step();
        rst = 1'b0;
        step();
        fetch(32'h2468_ACE0, 3);
        chk("post_rst_opcode", 32'(opcode), 32'(4'h2));

        step();
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
